// File: rtl/muldiv_seq.sv
// Iterative RV32IM M-extension unit: radix-2 shift-add multiplier and restoring
// divider sharing one 64-bit accumulator, with registered BUSY/RESULT outputs.
module muldiv_seq (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [4:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        RESULT_VALID,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [31:0] m_q, m_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;
  logic [31:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [2:0]  f3;
  logic        signed1, signed2, neg1, neg2, neg_start;
  logic [31:0] mag1, mag2, special_res;
  logic        div0, ovf, special, start_ok;

  logic [32:0] mul_sum, div_sh, div_diff;
  logic [63:0] mul_next, div_next, step, prod;
  logic [31:0] quo_rem, final_res;

  always_comb begin
    f3          = SELECT[2:0];
    signed1     = ~f3[0] | (f3 == 3'b001);
    signed2     = f3[2] ? ~f3[0] : ~f3[1];
    neg1        = signed1 & DATA1[31];
    neg2        = signed2 & DATA2[31];
    mag1        = neg1 ? -DATA1 : DATA1;
    mag2        = neg2 ? -DATA2 : DATA2;
    neg_start   = (f3 == 3'b110) ? neg1 : (neg1 ^ neg2);
    div0        = (DATA2 == '0);
    ovf         = ~f3[0] & (DATA1 == 32'h8000_0000) & (DATA2 == '1);
    special     = f3[2] & (div0 | ovf);
    special_res = div0 ? (f3[1] ? DATA1 : '1) : (f3[1] ? '0 : 32'h8000_0000);
    start_ok    = START & ~FLUSH & (SELECT[4:3] == 2'b01);
  end

  // One iteration of either algorithm; sign is folded in only on the last step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_sh    = acc_q[63:31];
    div_diff  = div_sh - {1'b0, m_q};
    div_next  = div_diff[32] ? {div_sh[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    step      = op_q[2] ? div_next : mul_next;
    prod      = neg_q ? -step : step;
    quo_rem   = op_q[1] ? step[63:32] : step[31:0];
    final_res = op_q[2] ? (neg_q ? -quo_rem : quo_rem)
                        : ((op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = special ? DONE : CALC;
      CALC:    if (FLUSH) state_d = IDLE;
               else if (count_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    op_d     = op_q;
    neg_d    = neg_q;
    m_d      = m_q;
    acc_d    = acc_q;
    res_d    = res_q;
    result_d = result_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (start_ok) begin
          op_d  = f3;
          neg_d = neg_start;
          m_d   = f3[2] ? mag2 : mag1;
          acc_d = {32'd0, f3[2] ? mag1 : mag2};
          if (special) res_d = special_res;
        end
      end
      CALC: begin
        acc_d   = step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) res_d = final_res;
      end
      DONE: begin
        if (!FLUSH) begin
          result_d = res_q;
          valid_d  = 1'b1;
        end
      end
      default: ;
    endcase
    // BUSY covers the result cycle too, so it drops one edge after DONE exits.
    busy_d = (state_d != IDLE) | valid_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      m_q      <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign BUSY         = busy_q;
  assign RESULT_VALID = valid_q;
  assign RESULT       = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, corner sequences, and
// random operations against an arithmetic reference model.
module tb_muldiv_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [4:0]  SELECT = '0;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        FLUSH = 1'b0;
  logic        BUSY;
  logic        RESULT_VALID;
  logic [31:0] RESULT;

  localparam logic [4:0] OP_MUL = 5'b01000, OP_MULH = 5'b01001, OP_MULHSU = 5'b01010;
  localparam logic [4:0] OP_MULHU = 5'b01011, OP_DIV = 5'b01100, OP_DIVU = 5'b01101;
  localparam logic [4:0] OP_REM = 5'b01110, OP_REMU = 5'b01111;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] prev_result = '0;

  muldiv_seq dut (
    .CLK(CLK), .RESET(RESET), .START(START), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .BUSY(BUSY), .RESULT_VALID(RESULT_VALID), .RESULT(RESULT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } tvec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    r  = '0;
    case (sel[2:0])
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hffff_ffff :
                  (a == 32'h8000_0000 && b == 32'hffff_ffff) ? 32'h8000_0000 : 32'(ia / ib);
      3'b101: r = (b == 0) ? 32'hffff_ffff : a / b;
      3'b110: r = (b == 0) ? a :
                  (a == 32'h8000_0000 && b == 32'hffff_ffff) ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [4:0] sel, input logic [31:0] a,
                                    input logic [31:0] b);
    return sel[2] && (b == 0 || (!sel[0] && a == 32'h8000_0000 && b == 32'hffff_ffff));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hffff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h7fff_ffff;
      default: return $urandom();
    endcase
  endfunction

  // Issue one op; returns #1 after the edge that raised RESULT_VALID.
  task automatic run_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit idle_after);
    int lat, n, busy_low;
    lat = is_special(sel, a, b) ? 1 : 33;
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; SELECT = '0; DATA1 = $urandom(); DATA2 = $urandom();
    n = 0; busy_low = 0;
    while (!RESULT_VALID && n < 40) begin
      if (!BUSY) busy_low++;
      @(posedge CLK); #1;
      n++;
    end
    check({name, " valid"}, {31'd0, RESULT_VALID}, 32'd1);
    check({name, " latency"}, n, lat);
    check({name, " busy_held"}, busy_low + (BUSY ? 0 : 1), 32'd0);
    check({name, " result"}, RESULT, exp);
    prev_result = exp;
    if (idle_after) begin
      @(posedge CLK); #1;
      check({name, " single_pulse"}, {31'd0, RESULT_VALID}, 32'd0);
      check({name, " busy_drop"}, {31'd0, BUSY}, 32'd0);
      check({name, " result_hold"}, RESULT, exp);
    end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int pulses, busy_hi;
    pulses = 0; busy_hi = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (RESULT_VALID) pulses++;
      if (BUSY) busy_hi++;
    end
    check({name, " no_valid"}, pulses, 32'd0);
    check({name, " no_busy"}, busy_hi, 32'd0);
  endtask

  initial begin
    tvec_t tv[12];
    int pulses;
    logic [31:0] seen;
    logic [4:0] rs;
    logic [31:0] ra, rb;

    tv[0]  = '{OP_MUL,    32'd7,          32'hffff_fffd, 32'hffff_ffeb};
    tv[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    tv[2]  = '{OP_MULHU,  32'hffff_ffff,  32'hffff_ffff, 32'hffff_fffe};
    tv[3]  = '{OP_MULHSU, 32'hffff_ffff,  32'hffff_ffff, 32'hffff_ffff};
    tv[4]  = '{OP_DIV,    32'hffff_fff9,  32'd2,         32'hffff_fffd};
    tv[5]  = '{OP_REM,    32'hffff_fff9,  32'd2,         32'hffff_ffff};
    tv[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14};
    tv[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2};
    tv[8]  = '{OP_DIVU,   32'd5,          32'd0,         32'hffff_ffff};
    tv[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5};
    tv[10] = '{OP_DIV,    32'h8000_0000,  32'hffff_ffff, 32'h8000_0000};
    tv[11] = '{OP_REM,    32'h8000_0000,  32'hffff_ffff, 32'd0};

    repeat (3) @(posedge CLK);
    #1;
    check("reset busy", {31'd0, BUSY}, 32'd0);
    check("reset valid", {31'd0, RESULT_VALID}, 32'd0);
    check("reset result", RESULT, 32'd0);
    RESET = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tv[i].sel, tv[i].a, tv[i].b, tv[i].exp, (i % 2) == 0);

    // Ignored issues: wrong opcode group, FLUSH beating START.
    SELECT = 5'b00000; DATA1 = 32'd3; DATA2 = 32'd4; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    check("sel0 busy", {31'd0, BUSY}, 32'd0);
    watch_quiet("sel0", 4);
    SELECT = 5'b10101; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    watch_quiet("sel_other", 4);
    SELECT = OP_DIVU; DATA1 = 32'd5; DATA2 = 32'd0; START = 1'b1; FLUSH = 1'b1;
    @(posedge CLK); #1; START = 1'b0; FLUSH = 1'b0;
    watch_quiet("flush_start", 4);
    check("flush_start result", RESULT, prev_result);

    // FLUSH at count=10, then an immediate new issue.
    run_op("pre_flush", OP_MUL, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 1'b1);
    SELECT = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (10) @(posedge CLK);
    #1; FLUSH = 1'b1;
    @(posedge CLK); #1; FLUSH = 1'b0;
    check("flush busy", {31'd0, BUSY}, 32'd0);
    watch_quiet("after_flush", 40);
    check("flush result_kept", RESULT, prev_result);
    run_op("post_flush", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b1);

    // RESET at count=20, then an immediate new issue.
    SELECT = OP_MULH; DATA1 = 32'h8000_0000; DATA2 = 32'h8000_0000; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (20) @(posedge CLK);
    #1; RESET = 1'b1;
    @(posedge CLK); #1; RESET = 1'b0;
    check("midreset busy", {31'd0, BUSY}, 32'd0);
    check("midreset valid", {31'd0, RESULT_VALID}, 32'd0);
    check("midreset result", RESULT, 32'd0);
    run_op("post_reset", OP_DIV, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 1'b1);

    // Second START during CALC must not queue or disturb the first op.
    SELECT = OP_MULHU; DATA1 = 32'hffff_ffff; DATA2 = 32'hffff_ffff; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (5) @(posedge CLK);
    #1; SELECT = OP_MUL; DATA1 = 32'd2; DATA2 = 32'd3; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    pulses = 0; seen = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (RESULT_VALID) begin pulses++; seen = RESULT; end
    end
    check("busy_start pulses", pulses, 32'd1);
    check("busy_start result", seen, 32'hffff_fffe);
    check("busy_start idle", {31'd0, BUSY}, 32'd0);

    // Randomised ops, mostly back-to-back at the minimum issue interval.
    for (int i = 0; i < 40; i++) begin
      rs = {2'b01, 3'($urandom_range(0, 7))};
      ra = pick();
      rb = pick();
      run_op($sformatf("rnd%0d sel=%b a=%h b=%h", i, rs, ra, rb), rs, ra, rb,
             ref_model(rs, ra, rb), (i % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32IM M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), sitting beside the single-cycle ALU in the EX stage. The control unit issues the operation with a one-cycle START pulse. The block holds BUSY, which the hazard unit uses to stall the pipeline, while a radix-2 shift-add multiplier or restoring divider runs. It then returns the 32-bit result with a one-cycle RESULT_VALID pulse.

## Interface
- No parameters; datapath width fixed at 32.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  issue request. Sampled only in IDLE.
- SELECT  in  5  operation code, {2'b01, funct3}:
  - 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU
  - 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU
- DATA1  in  32  rs1 value: multiplicand or dividend.
- DATA2  in  32  rs2 value: multiplier or divisor.
- FLUSH  in  1  abort the current operation (branch mispredict or trap).
- BUSY  out  1  high whenever state is not IDLE.
- RESULT_VALID  out  1  one-cycle pulse when RESULT is new.
- RESULT  out  32  last completed result; held until the next completion.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC when START=1 and SELECT[4:3]=01.
  - The edge latches the op, operand magnitudes, result-sign flags and count=0.
  - START with any other SELECT is ignored; the block stays IDLE.
- IDLE → DONE directly (special case) when START=1, op is a divide/remainder, and either:
  - DATA2=0, or
  - the op is signed, DATA1=0x80000000 and DATA2=0xFFFFFFFF.
- CALC runs one iteration per cycle; count increments. At count=31 the iteration completes and the state moves to DONE.
- DONE → IDLE unconditionally after one cycle.
- Signed handling: signed operands are converted to magnitude on entry. Sign is applied once on the CALC→DONE transition.
  - MUL/MULH: sign = s1 ^ s2.
  - MULHSU: sign = s1, and DATA2 is treated as unsigned.
  - DIV: sign = s1 ^ s2.
  - REM: sign = s1.
- Multiply: 64-bit product. MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32] of the signed-corrected 64-bit product.
- Divide: 32-step restoring division on a 33-bit partial remainder. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = DATA1.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- START while BUSY is ignored; no queuing.
- FLUSH in CALC or DONE: the next state is IDLE, RESULT_VALID stays 0, RESULT is unchanged.
  - FLUSH and START together in IDLE: FLUSH wins and nothing starts.
- RESET, at any point including mid-operation: state IDLE, count 0, BUSY=0, RESULT_VALID=0, RESULT=0x00000000. Internal operand registers are cleared.

## Timing
- Outputs are registered; no combinational input-to-output path.
- START sampled high at edge E0:
  - Normal op: BUSY=1 from after E0 through the DONE cycle. RESULT_VALID=1 and RESULT updated in the cycle after edge E0+33. BUSY=0 after E0+34.
  - Special case: RESULT_VALID=1 in the cycle after E0+1. BUSY=0 after E0+2.
- Back-to-back: a new START is accepted on the first edge where state is IDLE, i.e. E0+34 for a normal op. Minimum issue interval is 34 cycles.
- RESULT_VALID is never high for more than one consecutive cycle.
- DATA1, DATA2 and SELECT need to be valid only on the accepting edge.

## Test plan
- MUL: DATA1=7, DATA2=0xFFFFFFFD (-3), START at E0 → RESULT_VALID exactly in the cycle after E0+33, RESULT=0xFFFFFFEB. BUSY high for 34 cycles.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide: DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with RESULT_VALID in the cycle after E0+1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Abort and reset:
  - FLUSH at count=10 → IDLE next cycle, no RESULT_VALID, RESULT keeps its previous value.
  - RESET at count=20 → BUSY=0, RESULT=0 next cycle.
  - A new START right after either is accepted normally.
- Ignored issues:
  - START with SELECT=00000 → no BUSY, no RESULT_VALID.
  - A second START during CALC → no effect; only one RESULT_VALID pulse, carrying the first op's result.
